ifu_imem_ws: RTL and testbench
==============================

// Module: ifu_imem_ws
// PURPOSE
//  Parametrised, clocked instruction memory for the IFU. Byte-organised, little-endian storage.
//  Programmed at run time through a word load port; there is no hard-coded program.
//  Serves fetches through a req/ready/valid handshake with a configurable number of wait states.
//  Detects misaligned and out-of-range fetches. Sits between the PC register and the decoder.
// PARAMETERS
//  DEPTH_BYTES  256  memory size in bytes; must be a multiple of 4 and >= 8
//  WAIT_CYCLES  1    extra wait states per fetch (0..15)
//  NOP_INSTR    32'h0000_0013  word returned on error and after reset (RV32I addi x0,x0,0)
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  reset        in   1   synchronous, active-high reset
//  load_en      in   1   write one 32-bit word this cycle
//  load_addr    in   32  byte address of the word to write; must be 4-aligned
//  load_data    in   32  word to write; byte [7:0] goes to load_addr, [31:24] to load_addr+3
//  load_err     out  1   one-cycle pulse: the load was dropped (misaligned or out of range)
//  fetch_req    in   1   fetch request; accepted when fetch_req & fetch_ready
//  pc           in   32  byte address of the fetch; sampled on acceptance
//  fetch_ready  out  1   block can accept a fetch this cycle
//  instr_valid  out  1   one-cycle pulse: instruction/fetch_err are valid
//  instruction  out  32  {mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]}
//  fetch_err    out  1   qualifies instr_valid: fetch was misaligned or out of range
// BEHAVIOUR
//  Reset (reset=1 at an edge):
//   - state<=IDLE; instr_valid=0; fetch_err=0; load_err=0; instruction=NOP_INSTR; wait counter=0.
//   - Memory contents are not cleared. Loads and fetches presented during reset are ignored.
//   - Reset mid-fetch aborts the fetch. No instr_valid is produced for it.
//  fetch_ready = (state==IDLE) & ~load_en & ~reset. A load has priority over a fetch in the same cycle.
//  FSM:
//   - IDLE: on acceptance, latch pc into pc_q and evaluate the error condition.
//     - err = (pc[1:0]!=0) | (pc > DEPTH_BYTES-4), computed without 32-bit overflow.
//     - err=1 -> RESP (no wait states).
//     - err=0 and WAIT_CYCLES==0 -> RESP.
//     - err=0 otherwise -> WAIT with cnt<=WAIT_CYCLES-1.
//   - WAIT: cnt decrements each cycle; cnt==0 -> RESP. Inputs fetch_req/pc are ignored.
//   - RESP: instr_valid=1 for exactly this cycle, then IDLE.
//     - instruction is registered on entry to RESP: memory word at pc_q, or NOP_INSTR if err.
//     - fetch_err = err. instruction holds its value until the next RESP or reset.
//  Latency:
//   - Fetch accepted at edge N -> instr_valid high in cycle N+1+WAIT_CYCLES (error: N+1).
//   - Back-to-back throughput: one fetch per WAIT_CYCLES+2 cycles.
//  Loads:
//   - Allowed in any state. Written at the clock edge when load_en=1.
//   - Misaligned (load_addr[1:0]!=0) or load_addr > DEPTH_BYTES-4 -> no write; load_err pulses next cycle.
//   - A load in the same cycle as the RESP-entry capture at the same address returns old data (read-first).
//     A load in any earlier cycle is visible.
//  Address width: only log2(DEPTH_BYTES) LSBs index memory; range check uses the full 32 bits (no aliasing).
//  The block ignores any pc change after acceptance; pc_q is used.
// TESTING
//  T1 load 0x00940333 @0, 0x413903b3 @4; WAIT_CYCLES=1; fetch pc=4 accepted at edge N
//     -> valid in cycle N+2, instruction=0x413903b3, fetch_err=0.
//  T2 fetch pc=2 -> valid after 1 cycle, fetch_err=1, instruction=0x00000013;
//     fetch pc=DEPTH_BYTES -> same; pc=DEPTH_BYTES-4 -> no error.
//  T3 load_en=1 and fetch_req=1 in the same IDLE cycle -> fetch_ready=0, word written;
//     fetch accepted next cycle returns the new word.
//  T4 load_addr=0x5 -> load_err pulse, memory unchanged (read-back of word @4 identical).
//  T5 reset asserted in WAIT (WAIT_CYCLES=3) -> no instr_valid, outputs at reset values,
//     fetch_ready=1 the cycle after reset deasserts, memory retained.
//  T6 WAIT_CYCLES=0, fetch_req held high with pc 0,4,8...
//     -> accepts every 2nd cycle, each valid 1 cycle after its acceptance, words in order.

Source files
------------

// File: rtl/ifu_imem_ws.sv
// ifu_imem_ws: byte-organised, little-endian instruction memory for the IFU.
// The memory is written at run time through a word load port. It serves fetches
// through a req/ready/valid handshake and adds a fixed number of wait states.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   load_en/addr/data      32-bit word write (4-aligned byte address)
//   load_err               one-cycle pulse after a dropped load
//   fetch_req, pc          fetch request and its byte address
//   fetch_ready            a fetch is accepted this cycle when fetch_req is high
//   instr_valid            one-cycle pulse; instruction and fetch_err are valid
//   instruction            fetched word, or NOP_INSTR on error; held between fetches
//   fetch_err              fetch was misaligned or out of range (qualified by instr_valid)
module ifu_imem_ws #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_err,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    output logic        fetch_ready,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic        fetch_err
);

    localparam int unsigned AW        = $clog2(DEPTH_BYTES);
    localparam int unsigned CW        = 4;
    // Highest legal word address. DEPTH_BYTES >= 8, so this cannot underflow,
    // and comparing against it avoids the 32-bit overflow of pc + 4.
    localparam logic [31:0] LAST_ADDR = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            lerr_q, lerr_d;
    logic [31:0]     instr_q, instr_d;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic            pc_bad;
    logic            load_bad;
    logic            load_wr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [31:0]     rd_word;

    // Full 32-bit range checks, so addresses beyond the memory never alias.
    assign pc_bad   = (pc[1:0] != 2'b00) || (pc > LAST_ADDR);
    assign load_bad = (load_addr[1:0] != 2'b00) || (load_addr > LAST_ADDR);
    assign load_wr  = load_en && !load_bad && !reset;

    // A load owns the cycle; the fetch waits.
    assign fetch_ready = (state_q == S_IDLE) && !load_en && !reset;
    assign accept      = fetch_req && fetch_ready;

    // RESP is entered straight from IDLE (zero wait states) using the live pc,
    // otherwise from WAIT using the latched pc_q.
    assign wr_idx  = load_addr[AW-1:0];
    assign rd_idx  = (state_q == S_IDLE) ? pc[AW-1:0] : pc_q;
    assign rd_word = {mem[AW'(rd_idx + AW'(3))], mem[AW'(rd_idx + AW'(2))],
                      mem[AW'(rd_idx + AW'(1))], mem[rd_idx]};

    // Storage: not reset; the read above sees the pre-edge contents (read-first).
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[wr_idx]                  <= load_data[7:0];
            mem[AW'(wr_idx + AW'(1))]    <= load_data[15:8];
            mem[AW'(wr_idx + AW'(2))]    <= load_data[23:16];
            mem[AW'(wr_idx + AW'(3))]    <= load_data[31:24];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        err_d   = err_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        lerr_d  = load_en && load_bad;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pc_d  = pc[AW-1:0];
                    err_d = pc_bad;
                    if (pc_bad || (WAIT_CYCLES == 0)) begin
                        state_d = S_RESP;
                        valid_d = 1'b1;
                        ferr_d  = pc_bad;
                        instr_d = pc_bad ? NOP_INSTR : rd_word;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    ferr_d  = err_q;
                    instr_d = err_q ? NOP_INSTR : rd_word;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            lerr_q  <= lerr_d;
            instr_q <= instr_d;
        end
    end

    assign instr_valid = valid_q;
    assign fetch_err   = ferr_q;
    assign load_err    = lerr_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_ifu_imem_ws.sv
// Bench for ifu_imem_ws: three instances with 1, 3 and 0 wait states.
module tb_ifu_imem_ws;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned NV  = 16;

    logic        clk;
    logic        reset       [3];
    logic        load_en     [3];
    logic [31:0] load_addr   [3];
    logic [31:0] load_data   [3];
    logic        load_err    [3];
    logic        fetch_req   [3];
    logic [31:0] pc          [3];
    logic        fetch_ready [3];
    logic        instr_valid [3];
    logic [31:0] instruction [3];
    logic        fetch_err   [3];

    int          wc [3];
    logic [7:0]  mdl [3][256];
    int          total;
    int          bad;

    typedef struct {
        logic        is_fetch;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [NV];

    ifu_imem_ws #(.DEPTH_BYTES(256), .WAIT_CYCLES(1), .NOP_INSTR(NOP)) u_w1 (
        .clk(clk), .reset(reset[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0]), .load_err(load_err[0]), .fetch_req(fetch_req[0]),
        .pc(pc[0]), .fetch_ready(fetch_ready[0]), .instr_valid(instr_valid[0]),
        .instruction(instruction[0]), .fetch_err(fetch_err[0]));

    ifu_imem_ws #(.DEPTH_BYTES(256), .WAIT_CYCLES(3), .NOP_INSTR(NOP)) u_w3 (
        .clk(clk), .reset(reset[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1]), .load_err(load_err[1]), .fetch_req(fetch_req[1]),
        .pc(pc[1]), .fetch_ready(fetch_ready[1]), .instr_valid(instr_valid[1]),
        .instruction(instruction[1]), .fetch_err(fetch_err[1]));

    ifu_imem_ws #(.DEPTH_BYTES(256), .WAIT_CYCLES(0), .NOP_INSTR(NOP)) u_w0 (
        .clk(clk), .reset(reset[2]), .load_en(load_en[2]), .load_addr(load_addr[2]),
        .load_data(load_data[2]), .load_err(load_err[2]), .fetch_req(fetch_req[2]),
        .pc(pc[2]), .fetch_ready(fetch_ready[2]), .instr_valid(instr_valid[2]),
        .instruction(instruction[2]), .fetch_err(fetch_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Address legality from first principles: word aligned and all 4 bytes inside 256.
    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (({32'h0, a} + 64'd4) > 64'd256);
    endfunction

    function automatic logic [31:0] mword(input int d, input logic [31:0] a);
        int i;
        i = int'(a[7:0]);
        return {mdl[d][i+3], mdl[d][i+2], mdl[d][i+1], mdl[d][i]};
    endfunction

    task automatic mset(input int d, input logic [31:0] a, input logic [31:0] v);
        for (int b = 0; b < 4; b++) mdl[d][int'(a[7:0]) + b] = v[8*b +: 8];
    endtask

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic do_load(input int d, input logic [31:0] a, input logic [31:0] v,
                           input logic exp_lerr);
        load_en[d]   = 1'b1;
        load_addr[d] = a;
        load_data[d] = v;
        @(negedge clk);
        load_en[d]   = 1'b0;
        load_addr[d] = $urandom;
        chk("load_err", 32'(load_err[d]), 32'(exp_lerr));
        if (!exp_lerr) mset(d, a, v);
        @(negedge clk);
        chk("load_err_pulse", 32'(load_err[d]), 32'd0);
    endtask

    task automatic do_fetch(input int d, input logic [31:0] a, input logic [31:0] exp_i,
                            input logic exp_e, input string tag);
        int k;
        fetch_req[d] = 1'b1;
        pc[d]        = a;
        #1;
        chk({tag, "_ready"}, 32'(fetch_ready[d]), 32'd1);
        @(negedge clk);
        fetch_req[d] = 1'b0;
        pc[d]        = $urandom;
        k = 0;
        while (!instr_valid[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), exp_e ? 32'd0 : 32'(wc[d]));
        chk({tag, "_instr"}, instruction[d], exp_i);
        chk({tag, "_err"}, 32'(fetch_err[d]), 32'(exp_e));
        @(negedge clk);
        chk({tag, "_vpulse"}, 32'(instr_valid[d]), 32'd0);
        chk({tag, "_hold"}, instruction[d], exp_i);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        logic [31:0] old_w;
        int          sel;
        bit          seen;

        total = 0;
        bad   = 0;
        wc[0] = 1;
        wc[1] = 3;
        wc[2] = 0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0094_0333, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h4139_03b3, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h0,         1'b0, 32'h4139_03b3};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 32'h0094_0333};
        vecs[4]  = '{1'b1, 32'h0000_0002, 32'h0,         1'b1, NOP};
        vecs[5]  = '{1'b1, 32'h0000_0100, 32'h0,         1'b1, NOP};
        vecs[6]  = '{1'b0, 32'h0000_00fc, 32'hcafe_f00d, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_00fc, 32'h0,         1'b0, 32'hcafe_f00d};
        vecs[8]  = '{1'b1, 32'hffff_fffc, 32'h0,         1'b1, NOP};
        vecs[9]  = '{1'b0, 32'h0000_0005, 32'h1111_1111, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0004, 32'h0,         1'b0, 32'h4139_03b3};
        vecs[11] = '{1'b0, 32'h0000_0100, 32'h2222_2222, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0104, 32'h3333_3333, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0004, 32'h0,         1'b0, 32'h4139_03b3};
        vecs[14] = '{1'b1, 32'h0000_0104, 32'h0,         1'b1, NOP};
        vecs[15] = '{1'b1, 32'h8000_0000, 32'h0,         1'b1, NOP};

        for (int i = 0; i < 3; i++) begin
            reset[i]     = 1'b1;
            load_en[i]   = 1'b0;
            load_addr[i] = 32'h0;
            load_data[i] = 32'h0;
            fetch_req[i] = 1'b0;
            pc[i]        = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", 32'(instr_valid[i]), 32'd0);
            chk("rst_instr", instruction[i], NOP);
            chk("rst_ferr", 32'(fetch_err[i]), 32'd0);
            chk("rst_lerr", 32'(load_err[i]), 32'd0);
            chk("rst_ready", 32'(fetch_ready[i]), 32'd1);
        end
        @(negedge clk);

        // Directed table on the one-wait-state instance.
        for (int i = 0; i < int'(NV); i++) begin
            if (vecs[i].is_fetch)
                do_fetch(0, vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_err, "vec");
            else
                do_load(0, vecs[i].addr, vecs[i].data, vecs[i].exp_err);
        end

        // Load and fetch together: load wins, fetch follows and sees the new word.
        load_en[0]   = 1'b1;
        load_addr[0] = 32'h8;
        load_data[0] = 32'h00a5_0533;
        fetch_req[0] = 1'b1;
        pc[0]        = 32'h8;
        #1;
        chk("t3_ready_blocked", 32'(fetch_ready[0]), 32'd0);
        @(negedge clk);
        load_en[0] = 1'b0;
        chk("t3_lerr", 32'(load_err[0]), 32'd0);
        mset(0, 32'h8, 32'h00a5_0533);
        do_fetch(0, 32'h8, 32'h00a5_0533, 1'b0, "t3");

        // Load landing on the same edge as the response capture returns old data.
        do_load(0, 32'h10, 32'h0111_1111, 1'b0);
        old_w        = mword(0, 32'h10);
        fetch_req[0] = 1'b1;
        pc[0]        = 32'h10;
        @(negedge clk);
        fetch_req[0] = 1'b0;
        load_en[0]   = 1'b1;
        load_addr[0] = 32'h10;
        load_data[0] = 32'h0222_2222;
        @(negedge clk);
        load_en[0] = 1'b0;
        chk("rf_valid", 32'(instr_valid[0]), 32'd1);
        chk("rf_old_data", instruction[0], old_w);
        mset(0, 32'h10, 32'h0222_2222);
        @(negedge clk);
        do_fetch(0, 32'h10, 32'h0222_2222, 1'b0, "rf_new");

        // Reset in the middle of a three-wait-state fetch.
        do_load(1, 32'h0, 32'h1122_3344, 1'b0);
        do_fetch(1, 32'h0, 32'h1122_3344, 1'b0, "w3");
        fetch_req[1] = 1'b1;
        pc[1]        = 32'h0;
        @(negedge clk);
        fetch_req[1] = 1'b0;
        @(negedge clk);
        reset[1]     = 1'b1;
        load_en[1]   = 1'b1;
        load_addr[1] = 32'h0;
        load_data[1] = 32'hffff_ffff;
        #1;
        chk("t5_ready_in_reset", 32'(fetch_ready[1]), 32'd0);
        @(negedge clk);
        reset[1]   = 1'b0;
        load_en[1] = 1'b0;
        chk("t5_valid", 32'(instr_valid[1]), 32'd0);
        chk("t5_instr", instruction[1], NOP);
        chk("t5_ferr", 32'(fetch_err[1]), 32'd0);
        chk("t5_lerr", 32'(load_err[1]), 32'd0);
        #1;
        chk("t5_ready_after", 32'(fetch_ready[1]), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (instr_valid[1]) seen = 1'b1;
        end
        chk("t5_no_valid", 32'(seen), 32'd0);
        do_fetch(1, 32'h0, 32'h1122_3344, 1'b0, "t5_retain");

        // Zero wait states with fetch_req held: one acceptance every second cycle.
        for (int i = 0; i < 4; i++) do_load(2, 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b0);
        fetch_req[2] = 1'b1;
        pc[2]        = 32'h0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t6_ready", 32'(fetch_ready[2]), 32'((c % 2) == 0));
            @(negedge clk);
            chk("t6_valid", 32'(instr_valid[2]), 32'((c % 2) == 0));
            if ((c % 2) == 0) begin
                chk("t6_instr", instruction[2], mword(2, 32'(2 * c)));
                pc[2] = pc[2] + 32'd4;
            end
        end
        fetch_req[2] = 1'b0;
        @(negedge clk);

        // Randomised traffic against the byte-array model on the one-wait-state instance.
        for (int i = 0; i < 64; i++) do_load(0, 32'(4 * i), $urandom, 1'b0);
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                a = {24'h0, 8'($urandom_range(0, 255))} | 32'h1;
            else if (sel == 1)
                a = ($urandom_range(0, 1) == 1) ? $urandom : 32'(256 + 4 * $urandom_range(0, 63));
            else
                a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 9) < 3) begin
                v = $urandom;
                do_load(0, a, v, addr_bad(a));
            end else begin
                do_fetch(0, a, addr_bad(a) ? NOP : mword(0, a), addr_bad(a), "rand");
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
